duty_ramp: RTL and testbench

DUTY_RAMP -- requirements
Module: duty_ramp

---
 rtl/duty_ramp_pkg.sv | 18 +
 rtl/duty_ramp_tick.sv | 32 +++
 rtl/duty_ramp.sv | 162 ++++++++++++++++
 tb/tb_duty_ramp.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/duty_ramp_pkg.sv
// Shared codes for the duty ramp generator: FSM state encoding (also driven
// onto PHASE) and MODE input codes, so the PWM controller and bench agree.
package duty_ramp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RISE    = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_FALL    = 3'd3,
    ST_HOLD_LO = 3'd4
  } state_e;

  localparam logic [1:0] MODE_TRI = 2'b00;
  localparam logic [1:0] MODE_SAW = 2'b01;
  localparam logic [1:0] MODE_FIX = 2'b10;
  localparam logic [1:0] MODE_OFF = 2'b11;

endpackage

// File: rtl/duty_ramp_tick.sv
// Step prescaler: counts 0..DIV-1 and pulses TICK for one cycle on the wrap.
// CLR holds the count at zero so a restart always waits a full DIV period.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CLR,
  output logic TICK
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    TICK  = 1'b0;
    cnt_d = cnt_q + 1'b1;
    if (CLR) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_d = '0;
      TICK  = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/duty_ramp.sv
// Duty-cycle ramp generator: triangle / sawtooth / fixed / off patterns,
// one duty update per step tick, offered to the PWM controller with VLD/ACK.
module duty_ramp
  import duty_ramp_pkg::*;
#(
  parameter int DW         = 8,
  parameter int STEP_DIV   = 195312,
  parameter int HOLD_STEPS = 64
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          EN,
  input  logic [1:0]    MODE,
  input  logic [DW-1:0] LEVEL,
  output logic [DW-1:0] DUTY,
  output logic          DUTY_VLD,
  input  logic          DUTY_ACK,
  output logic [2:0]    PHASE
);

  localparam int            HW        = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);
  localparam logic [DW-1:0] DMAX      = '1;

  state_e        state_q, state_d;
  logic [DW-1:0] duty_q, duty_d, new_duty;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    mode_q, mode_d;
  logic          vld_q, vld_d;
  logic          en_q;
  logic          upd;
  logic          tick;

  tick_gen #(.DIV(STEP_DIV)) u_tick (
    .CLK  (CLK),
    .RST_N(RST_N),
    .CLR  (!EN),
    .TICK (tick)
  );

  // mode_q is the mode the FSM last acted on; it detects MODE changes in the
  // ramp states and lets off mode emit its single zero.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    mode_d   = mode_q;
    upd      = 1'b0;
    new_duty = duty_q;
    if (!EN) begin
      state_d = ST_IDLE;
      hold_d  = '0;
      if (en_q) begin
        upd      = 1'b1;
        new_duty = '0;
        mode_d   = MODE_OFF;
      end
    end else if (tick) begin
      if (state_q != ST_IDLE && MODE != mode_q) begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            mode_d = MODE;
            case (MODE)
              MODE_TRI, MODE_SAW: begin
                state_d  = ST_RISE;
                upd      = 1'b1;
                new_duty = '0;
              end
              MODE_FIX: if (LEVEL != duty_q) begin
                upd      = 1'b1;
                new_duty = LEVEL;
              end
              default: if (mode_q != MODE_OFF) begin
                upd      = 1'b1;
                new_duty = '0;
              end
            endcase
          end
          ST_RISE: begin
            upd = 1'b1;
            if (mode_q == MODE_SAW) begin
              new_duty = duty_q + 1'b1;
            end else begin
              new_duty = (duty_q == DMAX) ? DMAX : duty_q + 1'b1;
              if (new_duty == DMAX) begin
                state_d = ST_HOLD_HI;
                hold_d  = '0;
              end
            end
          end
          ST_HOLD_HI: begin
            upd = 1'b1;
            if (hold_q == HOLD_LAST) begin
              state_d = ST_FALL;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
          ST_FALL: begin
            upd      = 1'b1;
            new_duty = (duty_q == '0) ? '0 : duty_q - 1'b1;
            if (new_duty == '0) begin
              state_d = ST_HOLD_LO;
              hold_d  = '0;
            end
          end
          ST_HOLD_LO: begin
            upd = 1'b1;
            if (hold_q == HOLD_LAST) begin
              state_d = ST_RISE;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end
        endcase
      end
    end
  end

  // Latest value wins; an ACK only retires VLD when nothing new arrives.
  always_comb begin
    duty_d = duty_q;
    vld_d  = vld_q;
    if (upd) begin
      duty_d = new_duty;
      vld_d  = 1'b1;
    end else if (DUTY_ACK) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      vld_q   <= 1'b0;
      hold_q  <= '0;
      mode_q  <= MODE_TRI;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      vld_q   <= vld_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
      en_q    <= EN;
    end
  end

  assign DUTY     = duty_q;
  assign DUTY_VLD = vld_q;
  assign PHASE    = state_q;

endmodule

// File: tb/tb_duty_ramp.sv
// Directed bench for duty_ramp with STEP_DIV=4, HOLD_STEPS=2; outputs sampled
// on the falling clock edge, expected values hand-derived per scenario.
module tb_duty_ramp;
  import duty_ramp_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       EN = 1'b0;
  logic [1:0] MODE = MODE_TRI;
  logic [7:0] LEVEL = 8'd0;
  logic [7:0] DUTY;
  logic       DUTY_VLD;
  logic       DUTY_ACK = 1'b1;
  logic [2:0] PHASE;

  int n_chk = 0;
  int n_fail = 0;

  duty_ramp #(.DW(8), .STEP_DIV(4), .HOLD_STEPS(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .LEVEL(LEVEL),
    .DUTY(DUTY), .DUTY_VLD(DUTY_VLD), .DUTY_ACK(DUTY_ACK), .PHASE(PHASE)
  );

  always #5 CLK = ~CLK;

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Advances at least one falling edge, stops at the next one with VLD high.
  task automatic wait_vld(input int budget, output int cycles, output bit seen);
    cycles = 0;
    do begin
      @(negedge CLK);
      cycles++;
    end while (!DUTY_VLD && cycles < budget);
    seen = DUTY_VLD;
  endtask

  task automatic test_reset();
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    cyc(3);
    n_chk++; if (DUTY !== 8'd0) begin n_fail++; $display("FAIL reset_duty: got %0d expected 0", DUTY); end
    n_chk++; if (DUTY_VLD !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", DUTY_VLD); end
    n_chk++; if (PHASE !== ST_IDLE) begin n_fail++; $display("FAIL reset_phase: got %0d expected %0d", PHASE, ST_IDLE); end
    RST_N = 1'b1;
    cyc(10);
    n_chk++; if (DUTY_VLD !== 1'b0) begin n_fail++; $display("FAIL idle_no_update: got vld %b expected 0", DUTY_VLD); end
  endtask

  task automatic test_triangle();
    int cn; bit seen; logic [7:0] exp_d; logic [2:0] exp_p;
    MODE = MODE_TRI;
    DUTY_ACK = 1'b1;
    EN = 1'b1;
    for (int i = 0; i < 516; i++) begin
      wait_vld(12, cn, seen);
      if (i <= 255)      exp_d = 8'(i);
      else if (i <= 257) exp_d = 8'd255;
      else if (i <= 512) exp_d = 8'(512 - i);
      else if (i <= 514) exp_d = 8'd0;
      else               exp_d = 8'd1;
      if (i < 255)       exp_p = ST_RISE;
      else if (i <= 256) exp_p = ST_HOLD_HI;
      else if (i <= 511) exp_p = ST_FALL;
      else if (i <= 513) exp_p = ST_HOLD_LO;
      else               exp_p = ST_RISE;
      n_chk++; if (!seen || DUTY !== exp_d) begin n_fail++; $display("FAIL tri_duty[%0d]: got %0d vld %b expected %0d", i, DUTY, seen, exp_d); end
      n_chk++; if (cn != 4) begin n_fail++; $display("FAIL tri_interval[%0d]: got %0d cycles expected 4", i, cn); end
      n_chk++; if (PHASE !== exp_p) begin n_fail++; $display("FAIL tri_phase[%0d]: got %0d expected %0d", i, PHASE, exp_p); end
    end
  endtask

  task automatic test_sawtooth();
    int cn; bit seen;
    MODE = MODE_SAW;
    wait_vld(16, cn, seen);
    n_chk++; if (!seen || DUTY !== 8'd0) begin n_fail++; $display("FAIL saw_first: got %0d vld %b expected 0", DUTY, seen); end
    n_chk++; if (cn != 8) begin n_fail++; $display("FAIL saw_mode_change_delay: got %0d cycles expected 8", cn); end
    for (int i = 1; i < 258; i++) begin
      wait_vld(12, cn, seen);
      n_chk++; if (!seen || DUTY !== 8'(i)) begin n_fail++; $display("FAIL saw_duty[%0d]: got %0d vld %b expected %0d", i, DUTY, seen, 8'(i)); end
      n_chk++; if (cn != 4) begin n_fail++; $display("FAIL saw_interval[%0d]: got %0d cycles expected 4", i, cn); end
      n_chk++; if (PHASE !== ST_RISE) begin n_fail++; $display("FAIL saw_phase[%0d]: got %0d expected %0d", i, PHASE, ST_RISE); end
    end
  endtask

  task automatic test_ack();
    int cn; bit seen; bit found;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      wait_vld(12, cn, seen);
      if (seen && DUTY == 8'd10) found = 1'b1;
    end
    n_chk++; if (!found) begin n_fail++; $display("FAIL ack_reach10: got %0d expected 10", DUTY); end
    DUTY_ACK = 1'b0;
    cyc(2);
    n_chk++; if (DUTY !== 8'd10 || DUTY_VLD !== 1'b1) begin n_fail++; $display("FAIL ack_hold_stable: got %0d/%b expected 10/1", DUTY, DUTY_VLD); end
    cyc(10);
    n_chk++; if (DUTY !== 8'd13 || DUTY_VLD !== 1'b1) begin n_fail++; $display("FAIL ack_overwrite: got %0d/%b expected 13/1", DUTY, DUTY_VLD); end
    DUTY_ACK = 1'b1;
    cyc(1);
    DUTY_ACK = 1'b0;
    n_chk++; if (DUTY !== 8'd13 || DUTY_VLD !== 1'b0) begin n_fail++; $display("FAIL ack_clear: got %0d/%b expected 13/0", DUTY, DUTY_VLD); end
    cyc(1);
    DUTY_ACK = 1'b1;
    cyc(1);
    DUTY_ACK = 1'b0;
    n_chk++; if (DUTY !== 8'd13 || DUTY_VLD !== 1'b0) begin n_fail++; $display("FAIL ack_idle_ignored: got %0d/%b expected 13/0", DUTY, DUTY_VLD); end
    cyc(1);
    n_chk++; if (DUTY !== 8'd14 || DUTY_VLD !== 1'b1) begin n_fail++; $display("FAIL ack_next_tick: got %0d/%b expected 14/1", DUTY, DUTY_VLD); end
    cyc(3);
    DUTY_ACK = 1'b1;
    cyc(1);
    n_chk++; if (DUTY !== 8'd15 || DUTY_VLD !== 1'b1) begin n_fail++; $display("FAIL ack_with_tick: got %0d/%b expected 15/1", DUTY, DUTY_VLD); end
    cyc(1);
    n_chk++; if (DUTY !== 8'd15 || DUTY_VLD !== 1'b0) begin n_fail++; $display("FAIL ack_after_tick: got %0d/%b expected 15/0", DUTY, DUTY_VLD); end
  endtask

  task automatic test_fixed_off();
    int cnt; logic [7:0] last;
    MODE = MODE_FIX;
    LEVEL = 8'h80;
    cnt = 0; last = 8'hxx;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (DUTY_VLD) begin cnt++; last = DUTY; end
    end
    n_chk++; if (cnt != 1) begin n_fail++; $display("FAIL fix_count_80: got %0d expected 1", cnt); end
    n_chk++; if (last !== 8'h80) begin n_fail++; $display("FAIL fix_value_80: got %0h expected 80", last); end
    n_chk++; if (PHASE !== ST_IDLE) begin n_fail++; $display("FAIL fix_phase: got %0d expected %0d", PHASE, ST_IDLE); end
    LEVEL = 8'h40;
    cnt = 0; last = 8'hxx;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (DUTY_VLD) begin cnt++; last = DUTY; end
    end
    n_chk++; if (cnt != 1) begin n_fail++; $display("FAIL fix_count_40: got %0d expected 1", cnt); end
    n_chk++; if (last !== 8'h40) begin n_fail++; $display("FAIL fix_value_40: got %0h expected 40", last); end
    MODE = MODE_OFF;
    cnt = 0; last = 8'hxx;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (DUTY_VLD) begin cnt++; last = DUTY; end
    end
    n_chk++; if (cnt != 1) begin n_fail++; $display("FAIL off_count: got %0d expected 1", cnt); end
    n_chk++; if (last !== 8'h00) begin n_fail++; $display("FAIL off_value: got %0h expected 0", last); end
  endtask

  task automatic test_en_toggle();
    int cn; int cnt; bit seen; bit found;
    MODE = MODE_TRI;
    found = 1'b0;
    for (int k = 0; k < 215 && !found; k++) begin
      wait_vld(12, cn, seen);
      if (seen && DUTY == 8'd200) found = 1'b1;
    end
    n_chk++; if (!found) begin n_fail++; $display("FAIL en_reach200: got %0d expected 200", DUTY); end
    EN = 1'b0;
    cyc(1);
    n_chk++; if (DUTY !== 8'd0 || DUTY_VLD !== 1'b1) begin n_fail++; $display("FAIL en_drop_update: got %0d/%b expected 0/1", DUTY, DUTY_VLD); end
    n_chk++; if (PHASE !== ST_IDLE) begin n_fail++; $display("FAIL en_drop_phase: got %0d expected %0d", PHASE, ST_IDLE); end
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      if (DUTY_VLD) cnt++;
    end
    n_chk++; if (cnt != 0) begin n_fail++; $display("FAIL en_low_quiet: got %0d updates expected 0", cnt); end
    EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_vld(12, cn, seen);
      n_chk++; if (!seen || DUTY !== 8'(i)) begin n_fail++; $display("FAIL en_restart[%0d]: got %0d vld %b expected %0d", i, DUTY, seen, i); end
      n_chk++; if (cn != 4) begin n_fail++; $display("FAIL en_restart_interval[%0d]: got %0d cycles expected 4", i, cn); end
    end
  endtask

  task automatic test_async_reset();
    int cn; bit seen; bit found;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      wait_vld(12, cn, seen);
      if (seen && DUTY == 8'd37) found = 1'b1;
    end
    n_chk++; if (!found) begin n_fail++; $display("FAIL rst_reach37: got %0d expected 37", DUTY); end
    DUTY_ACK = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    n_chk++; if (DUTY !== 8'd0 || DUTY_VLD !== 1'b0) begin n_fail++; $display("FAIL rst_async: got %0d/%b expected 0/0", DUTY, DUTY_VLD); end
    n_chk++; if (PHASE !== ST_IDLE) begin n_fail++; $display("FAIL rst_async_phase: got %0d expected %0d", PHASE, ST_IDLE); end
    cyc(2);
    n_chk++; if (DUTY !== 8'd0 || DUTY_VLD !== 1'b0) begin n_fail++; $display("FAIL rst_held: got %0d/%b expected 0/0", DUTY, DUTY_VLD); end
    RST_N = 1'b1;
    DUTY_ACK = 1'b1;
    wait_vld(12, cn, seen);
    n_chk++; if (!seen || DUTY !== 8'd0) begin n_fail++; $display("FAIL rst_resume: got %0d vld %b expected 0", DUTY, seen); end
    n_chk++; if (cn != 4) begin n_fail++; $display("FAIL rst_resume_interval: got %0d cycles expected 4", cn); end
  endtask

  initial begin
    test_reset();
    test_triangle();
    test_sawtooth();
    test_ack();
    test_fixed_off();
    test_en_toggle();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
